// File: rtl/instr_encoder_loader.sv
// Builds RV32I instruction words from field-level commands and streams them into
// instruction memory, closing every program with the 0x0000007F halt word.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_type,
  input  logic [2:0]        cmd_funct3,
  input  logic              cmd_f7b5,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  input  logic              finish,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0] HALT_WORD = 32'h0000_007F;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IALU   = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  // Highest word address; it is kept free so the halt word always fits.
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, HALT, DONE} state_t;

  state_t          state;
  logic [31:0]     enc_word;
  logic            accept;
  logic [ADDR_W:0] count_inc;
  logic            unused_imm;

  assign accept     = (state == LOAD) && cmd_valid && cmd_ready;
  assign count_inc  = count + 1'b1;
  assign unused_imm = ^cmd_imm[31:21];

  always_comb begin
    enc_word = HALT_WORD;
    case (cmd_type)
      3'd0: enc_word = {1'b0, cmd_f7b5, 5'b0, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, OP_R};
      3'd1: begin
        // Shift-immediates carry a 5-bit shamt with funct7 in the upper bits.
        if (cmd_funct3 == 3'b001 || cmd_funct3 == 3'b101)
          enc_word = {1'b0, cmd_f7b5, 5'b0, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, OP_IALU};
        else
          enc_word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_IALU};
      end
      3'd2: enc_word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_LOAD};
      3'd3: enc_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], OP_STORE};
      3'd4: enc_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                        cmd_imm[4:1], cmd_imm[11], OP_BRANCH};
      3'd5: enc_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OP_JAL};
      3'd6: enc_word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OP_JALR};
      default: enc_word = HALT_WORD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            count     <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= enc_word;
            count      <= count_inc;
          end
          // A command accepted alongside finish is written before the halt word.
          if (finish) begin
            state     <= HALT;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= accept ? (count_inc < LAST) : (count < LAST);
          end
        end
        HALT: begin
          imem_we    <= 1'b1;
          imem_addr  <= count[ADDR_W-1:0];
          imem_wdata <= HALT_WORD;
          count      <= count_inc;
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed check of instr_encoder_loader at two memory depths,
// against a transaction-level model with its own field arithmetic.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, cmd_valid, cmd_f7b5, finish;
  logic [2:0]  cmd_type, cmd_funct3;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [31:0] cmd_imm;

  logic        big_ready, big_we, big_busy, big_done;
  logic [7:0]  big_addr;
  logic [31:0] big_wdata;
  logic [8:0]  big_count;
  logic        small_ready, small_we, small_busy, small_done;
  logic [1:0]  small_addr;
  logic [31:0] small_wdata;
  logic [2:0]  small_count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) u_big (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(big_ready),
    .cmd_type(cmd_type), .cmd_funct3(cmd_funct3), .cmd_f7b5(cmd_f7b5), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .finish(finish),
    .imem_we(big_we), .imem_addr(big_addr), .imem_wdata(big_wdata), .count(big_count),
    .busy(big_busy), .done(big_done));

  instr_encoder_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_ready(small_ready),
    .cmd_type(cmd_type), .cmd_funct3(cmd_funct3), .cmd_f7b5(cmd_f7b5), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .finish(finish),
    .imem_we(small_we), .imem_addr(small_addr), .imem_wdata(small_wdata), .count(small_count),
    .busy(small_busy), .done(small_done));

  logic        o_ready[2], o_we[2], o_busy[2], o_done[2];
  logic [7:0]  o_addr[2];
  logic [31:0] o_wdata[2];
  logic [8:0]  o_cnt[2];

  always_comb begin
    o_ready[0] = big_ready;   o_ready[1] = small_ready;
    o_we[0]    = big_we;      o_we[1]    = small_we;
    o_busy[0]  = big_busy;    o_busy[1]  = small_busy;
    o_done[0]  = big_done;    o_done[1]  = small_done;
    o_addr[0]  = big_addr;    o_addr[1]  = {6'b0, small_addr};
    o_wdata[0] = big_wdata;   o_wdata[1] = small_wdata;
    o_cnt[0]   = big_count;   o_cnt[1]   = {6'b0, small_count};
  end

  int          n_checks = 0;
  int          n_fail = 0;
  string       nm[2] = '{"big", "small"};
  int          depth[2] = '{256, 4};

  bit          m_loading[2], m_halting[2], m_done[2], m_we[2];
  int          m_cnt[2], m_addr[2];
  logic [31:0] m_wdata[2];
  logic [31:0] exp_mem[256];
  logic [31:0] cap_mem[256];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Encoding rebuilt from the field layout with shifts and masks.
  function automatic logic [31:0] ref_encode(input logic [2:0] t, input logic [2:0] f3,
      input logic f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm);
    logic [31:0] d, s1, s2, fn;
    d  = 32'(rd) << 7;
    s1 = 32'(rs1) << 15;
    s2 = 32'(rs2) << 20;
    fn = 32'(f3) << 12;
    case (t)
      3'd0: return (32'(f7) << 30) | s2 | s1 | fn | d | 32'h33;
      3'd1: if (f3 == 3'd1 || f3 == 3'd5)
              return (32'(f7) << 30) | ((imm & 32'h1F) << 20) | s1 | fn | d | 32'h13;
            else
              return ((imm & 32'hFFF) << 20) | s1 | fn | d | 32'h13;
      3'd2: return ((imm & 32'hFFF) << 20) | s1 | fn | d | 32'h03;
      3'd3: return (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | fn | ((imm & 32'h1F) << 7) | 32'h23;
      3'd4: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | fn
                   | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
      3'd6: return ((imm & 32'hFFF) << 20) | s1 | d | 32'h67;
      default: return 32'h7F;
    endcase
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit acc;
      if (rst) begin
        m_loading[i] = 0; m_halting[i] = 0; m_done[i] = 0; m_we[i] = 0;
        m_cnt[i] = 0; m_addr[i] = 0; m_wdata[i] = 0;
      end else begin
        acc = m_loading[i] && (m_cnt[i] < depth[i] - 1) && cmd_valid;
        m_we[i] = 0;
        if (m_halting[i]) begin
          m_we[i] = 1; m_addr[i] = m_cnt[i]; m_wdata[i] = 32'h7F;
          m_cnt[i]++; m_halting[i] = 0; m_done[i] = 1;
        end else if (m_loading[i]) begin
          if (acc) begin
            m_we[i] = 1; m_addr[i] = m_cnt[i];
            m_wdata[i] = ref_encode(cmd_type, cmd_funct3, cmd_f7b5, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
            m_cnt[i]++;
          end
          if (finish) begin m_loading[i] = 0; m_halting[i] = 1; end
        end else if (start) begin
          m_loading[i] = 1; m_cnt[i] = 0; m_done[i] = 0;
        end
        if (i == 0 && m_we[0]) exp_mem[m_addr[0]] = m_wdata[0];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      checkOutput({nm[i], "_ready"}, 32'(o_ready[i]), 32'(m_loading[i] && (m_cnt[i] < depth[i] - 1)));
      checkOutput({nm[i], "_we"}, 32'(o_we[i]), 32'(m_we[i]));
      checkOutput({nm[i], "_busy"}, 32'(o_busy[i]), 32'(m_loading[i] || m_halting[i]));
      checkOutput({nm[i], "_done"}, 32'(o_done[i]), 32'(m_done[i]));
      checkOutput({nm[i], "_count"}, 32'(o_cnt[i]), 32'(m_cnt[i]));
      if (m_we[i]) begin
        checkOutput({nm[i], "_addr"}, 32'(o_addr[i]), 32'(m_addr[i]));
        checkOutput({nm[i], "_wdata"}, o_wdata[i], m_wdata[i]);
      end
    end
    if (big_we === 1'b1) cap_mem[big_addr] = big_wdata;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [2:0] t,
      input logic [2:0] f3, input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic fin);
    start = s; cmd_valid = v; cmd_type = t; cmd_funct3 = f3; cmd_f7b5 = f7;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; finish = fin;
    step();
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    idle_cycle();
    rst = 0;
  endtask

  task automatic clear_mems();
    for (int a = 0; a < 256; a++) begin
      exp_mem[a] = 32'hDEAD_BEEF;
      cap_mem[a] = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    rst = 1;
    clear_mems();
    idle_cycle();
    idle_cycle();
    checkOutput("rst_addr", 32'(big_addr), 32'h0);
    checkOutput("rst_wdata", big_wdata, 32'h0);
    rst = 0;

    // Encoding vectors from the field examples.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_after_start", 32'(big_ready), 32'h1);
    applyStimulus(0, 1, 0, 3'b000, 0, 3, 1, 2, 0, 0);
    checkOutput("enc_add", big_wdata, 32'h002081B3);
    checkOutput("enc_add_addr", 32'(big_addr), 32'h0);
    applyStimulus(0, 1, 0, 3'b000, 1, 5, 6, 7, 0, 0);
    checkOutput("enc_sub", big_wdata, 32'h407302B3);
    checkOutput("enc_sub_addr", 32'(big_addr), 32'h1);
    applyStimulus(0, 1, 1, 3'b000, 0, 1, 0, 0, 32'hFFFF_FFFF, 0);
    checkOutput("enc_addi", big_wdata, 32'hFFF00093);
    applyStimulus(0, 1, 1, 3'b101, 1, 2, 1, 0, 32'd3, 0);
    checkOutput("enc_srai", big_wdata, 32'h4030D113);
    applyStimulus(0, 1, 3, 3'b010, 0, 0, 1, 2, 32'd8, 0);
    checkOutput("enc_sw", big_wdata, 32'h0020A423);
    applyStimulus(0, 1, 4, 3'b000, 0, 0, 1, 2, -32'sd4, 0);
    checkOutput("enc_beq", big_wdata, 32'hFE208EE3);
    applyStimulus(0, 1, 5, 3'b000, 0, 1, 0, 0, 32'd8, 0);
    checkOutput("enc_jal", big_wdata, 32'h008000EF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_cycle();
    checkOutput("halt_word", big_wdata, 32'h0000007F);
    checkOutput("halt_done", 32'(big_done), 32'h1);

    // Back-to-back commands with finish riding on the third.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 2, 3, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4, 5, 0, 32'd100, 0);
    checkOutput("b2b_addr1", 32'(big_addr), 32'h1);
    applyStimulus(0, 1, 2, 3'b010, 0, 6, 7, 0, 32'd12, 1);
    checkOutput("b2b_addr2", 32'(big_addr), 32'h2);
    checkOutput("b2b_ready_halt", 32'(big_ready), 32'h0);
    idle_cycle();
    checkOutput("b2b_halt_addr", 32'(big_addr), 32'h3);
    checkOutput("b2b_halt_we", 32'(big_we), 32'h1);
    checkOutput("b2b_count", 32'(big_count), 32'h4);
    idle_cycle();
    checkOutput("b2b_we_drop", 32'(big_we), 32'h0);
    checkOutput("b2b_done_held", 32'(big_done), 32'h1);

    // Capacity limit seen on the 4-word instance.
    do_reset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, 0, 5'(k + 1), 1, 2, 0, 0);
    checkOutput("cap_ready_low", 32'(small_ready), 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 9, 1, 2, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 9, 1, 2, 0, 0);
    checkOutput("cap_no_write", 32'(small_we), 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 9, 1, 2, 0, 1);
    idle_cycle();
    checkOutput("cap_halt_addr", 32'(small_addr), 32'h3);
    checkOutput("cap_halt_word", small_wdata, 32'h0000007F);
    checkOutput("cap_count", 32'(small_count), 32'h4);

    // Reset mid-load, then restart and a start ignored while loading.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 2, 2, 2, 0, 0);
    rst = 1;
    applyStimulus(0, 1, 0, 0, 0, 3, 3, 3, 0, 1);
    rst = 0;
    checkOutput("mid_rst_we", 32'(big_we), 32'h0);
    checkOutput("mid_rst_count", 32'(big_count), 32'h0);
    checkOutput("mid_rst_addr", 32'(big_addr), 32'h0);
    checkOutput("mid_rst_wdata", big_wdata, 32'h0);
    idle_cycle();
    idle_cycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 4, 4, 0, 32'd7, 0);
    checkOutput("restart_addr", 32'(big_addr), 32'h0);
    applyStimulus(1, 1, 1, 0, 0, 5, 5, 0, 32'd9, 0);
    checkOutput("start_in_load_count", 32'(big_count), 32'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_cycle();

    // Random programs, with written memory compared at the end of each.
    for (int p = 0; p < 25; p++) begin
      int len;
      clear_mems();
      len = $urandom_range(1, 40);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < len; c++)
        applyStimulus(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0),
                      3'($urandom_range(0, 7)), 3'($urandom), 1'($urandom), 5'($urandom),
                      5'($urandom), 5'($urandom), $urandom, 1'(c == len - 1));
      for (int k = 0; k < 5 && big_done !== 1'b1; k++) idle_cycle();
      checkOutput("done_timeout", 32'(big_done), 32'h1);
      for (int a = 0; a < m_cnt[0]; a++)
        checkOutput($sformatf("mem_p%0d_a%0d", p, a), cap_mem[a], exp_mem[a]);
      if ($urandom_range(0, 4) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
